// File: rtl/rf_debug_sequencer_pkg.sv
// rtl/rf_debug_sequencer_pkg.sv - shared constants and state encoding for the register-file debug sequencer
package rf_debug_sequencer_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 16;

  localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DUMP_RD  = 3'd1,
    DUMP_OUT = 3'd2,
    LOAD     = 3'd3,
    DONE     = 3'd4
  } seqState_t;

  function automatic logic isLastIndex(input logic [ADDR_W-1:0] idx);
    return idx == LAST_INDEX;
  endfunction

endpackage

// File: rtl/rf_debug_sequencer_if.sv
// rtl/rf_debug_sequencer_if.sv - command, register-file and stream signals between the sequencer and its surroundings
interface rf_debug_sequencer_if;
  import rf_debug_sequencer_pkg::*;

  logic              cmd_valid;
  logic              cmd_load;
  logic              busy;
  logic              cpu_stall;
  logic [ADDR_W-1:0] rf_src_reg;
  logic [DATA_W-1:0] rf_src_data;
  logic [ADDR_W-1:0] rf_dst_reg;
  logic              rf_write;
  logic [DATA_W-1:0] rf_dst_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              done;

  modport master (
    input  cmd_valid, cmd_load, rf_src_data, out_ready, in_valid, in_data,
    output busy, cpu_stall, rf_src_reg, rf_dst_reg, rf_write, rf_dst_data,
           out_valid, out_data, out_last, in_ready, done
  );

  modport slave (
    output cmd_valid, cmd_load, rf_src_data, out_ready, in_valid, in_data,
    input  busy, cpu_stall, rf_src_reg, rf_dst_reg, rf_write, rf_dst_data,
           out_valid, out_data, out_last, in_ready, done
  );

endinterface

// File: rtl/rf_debug_sequencer.sv
// rtl/rf_debug_sequencer.sv - walks all registers in order, dumping them to a stream or loading them from one
module rf_debug_sequencer
  import rf_debug_sequencer_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  rf_debug_sequencer_if.master dbg
);

  seqState_t         state, stateNext;
  logic [ADDR_W-1:0] index, indexNext;
  logic              busyReg, busyNext;
  logic [DATA_W-1:0] outData, outDataNext;
  logic              outValid, outValidNext;
  logic              outLast, outLastNext;
  logic              inReady, inReadyNext;
  logic [ADDR_W-1:0] dstReg, dstRegNext;
  logic [DATA_W-1:0] dstData, dstDataNext;
  logic              rfWrite, rfWriteNext;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      index    <= '0;
      busyReg  <= 1'b0;
      outData  <= '0;
      outValid <= 1'b0;
      outLast  <= 1'b0;
      inReady  <= 1'b0;
      dstReg   <= '0;
      dstData  <= '0;
      rfWrite  <= 1'b0;
    end else begin
      state    <= stateNext;
      index    <= indexNext;
      busyReg  <= busyNext;
      outData  <= outDataNext;
      outValid <= outValidNext;
      outLast  <= outLastNext;
      inReady  <= inReadyNext;
      dstReg   <= dstRegNext;
      dstData  <= dstDataNext;
      rfWrite  <= rfWriteNext;
    end
  end

  always_comb begin
    stateNext    = state;
    indexNext    = index;
    busyNext     = busyReg;
    outDataNext  = outData;
    outValidNext = outValid;
    outLastNext  = outLast;
    inReadyNext  = inReady;
    dstRegNext   = dstReg;
    dstDataNext  = dstData;
    rfWriteNext  = 1'b0;

    unique case (state)
      IDLE: begin
        if (dbg.cmd_valid) begin
          indexNext = '0;
          busyNext  = 1'b1;
          if (dbg.cmd_load) begin
            stateNext   = LOAD;
            inReadyNext = 1'b1;
          end else begin
            stateNext = DUMP_RD;
          end
        end
      end

      DUMP_RD: begin
        outDataNext  = dbg.rf_src_data;
        outValidNext = 1'b1;
        outLastNext  = isLastIndex(index);
        stateNext    = DUMP_OUT;
      end

      DUMP_OUT: begin
        if (dbg.out_ready) begin
          outValidNext = 1'b0;
          outLastNext  = 1'b0;
          if (outLast) begin
            stateNext = DONE;
          end else begin
            indexNext = index + ADDR_W'(1);
            stateNext = DUMP_RD;
          end
        end
      end

      // After the final word is accepted in_ready drops and LOAD lingers one cycle
      // so the write pulse lands before DONE.
      LOAD: begin
        if (inReady && dbg.in_valid) begin
          dstRegNext  = index;
          dstDataNext = dbg.in_data;
          rfWriteNext = 1'b1;
          if (isLastIndex(index)) begin
            inReadyNext = 1'b0;
          end else begin
            indexNext = index + ADDR_W'(1);
          end
        end else if (!inReady) begin
          stateNext = DONE;
        end
      end

      DONE: begin
        busyNext  = 1'b0;
        stateNext = IDLE;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign dbg.busy        = busyReg;
  assign dbg.cpu_stall   = busyReg;
  assign dbg.rf_src_reg  = index;
  assign dbg.rf_dst_reg  = dstReg;
  assign dbg.rf_dst_data = dstData;
  assign dbg.rf_write    = rfWrite;
  assign dbg.out_valid   = outValid;
  assign dbg.out_data    = outData;
  assign dbg.out_last    = outLast;
  assign dbg.in_ready    = inReady;
  assign dbg.done        = (state == DONE);

endmodule

// File: tb/tb_rf_debug_sequencer.sv
// tb/tb_rf_debug_sequencer.sv - directed self-checking bench for rf_debug_sequencer with a register-file model
module tb_rf_debug_sequencer;
  import rf_debug_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rf_debug_sequencer_if dbg();

  rf_debug_sequencer dut (
    .clk (clk),
    .rst (rst),
    .dbg (dbg)
  );

  int nChecks = 0;
  int nFails  = 0;

  logic [15:0] regs [16];
  logic        preEn  = 1'b0;
  logic [3:0]  preIdx = '0;
  logic [15:0] preVal = '0;

  assign dbg.rf_src_data = regs[dbg.rf_src_reg];

  always @(posedge clk) begin
    if (dbg.rf_write) regs[dbg.rf_dst_reg] <= dbg.rf_dst_data;
    else if (preEn)   regs[preIdx] <= preVal;
  end

  logic [15:0] dumpQ[$];
  logic        lastQ[$];
  logic [3:0]  wrIdxQ[$];
  logic [15:0] wrDataQ[$];
  int          doneCount = 0;
  logic        clrMon = 1'b0;

  always @(negedge clk) begin
    if (clrMon) begin
      dumpQ.delete(); lastQ.delete(); wrIdxQ.delete(); wrDataQ.delete();
      doneCount = 0;
    end else begin
      if (dbg.out_valid && dbg.out_ready) begin
        dumpQ.push_back(dbg.out_data);
        lastQ.push_back(dbg.out_last);
      end
      if (dbg.rf_write) begin
        wrIdxQ.push_back(dbg.rf_dst_reg);
        wrDataQ.push_back(dbg.rf_dst_data);
      end
      if (dbg.done) doneCount++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    clrMon = 1'b1;
    @(negedge clk);
    #1;
    clrMon = 1'b0;
  endtask

  task automatic preload(input int idx, input logic [15:0] val);
    preEn = 1'b1; preIdx = 4'(idx); preVal = val;
    step();
    preEn = 1'b0;
  endtask

  task automatic cmd(input logic isLoad);
    dbg.cmd_valid = 1'b1; dbg.cmd_load = isLoad;
    step();
    dbg.cmd_valid = 1'b0; dbg.cmd_load = 1'b0;
  endtask

  function automatic logic [46:0] outVec();
    return {dbg.busy, dbg.cpu_stall, dbg.rf_write, dbg.out_valid, dbg.out_last, dbg.in_ready,
            dbg.done, dbg.out_data, dbg.rf_src_reg, dbg.rf_dst_reg, dbg.rf_dst_data};
  endfunction

  task automatic do_dump(output int doneAt);
    clear_mon();
    dbg.out_ready = 1'b1;
    cmd(1'b0);
    doneAt = -1;
    for (int c = 1; c <= 200; c++) begin
      step();
      if (dbg.done) begin doneAt = c; break; end
    end
    step();
  endtask

  task automatic do_load(input logic [15:0] base, input bit gaps, input bit poke, output int doneAt);
    int  sent;
    logic xfer;
    clear_mon();
    cmd(1'b1);
    sent = 0;
    doneAt = -1;
    for (int c = 1; c <= 200; c++) begin
      dbg.in_valid  = (sent < 16) && (!gaps || (c % 2 == 1));
      dbg.in_data   = 16'(base + 16'(sent));
      dbg.cmd_valid = poke && (c == 5 || c == 6);
      dbg.cmd_load  = 1'b0;
      xfer = dbg.in_valid && dbg.in_ready;
      step();
      if (xfer) sent++;
      if (dbg.done) begin doneAt = c; break; end
    end
    dbg.in_valid = 1'b0; dbg.cmd_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) step();
    nChecks++;
    if (outVec() !== 47'd0) begin nFails++; $display("FAIL reset_outputs: got %h expected 0", outVec()); end
    nChecks++;
    if (dut.state !== IDLE) begin nFails++; $display("FAIL reset_state: got %0d expected %0d", dut.state, IDLE); end
    rst = 1'b1;
    step();
    for (int i = 0; i < 16; i++) preload(i, (i == 3) ? 16'hBEEF : 16'(16'h1000 + i));
    clear_mon();
    dbg.out_ready = 1'b1;
    cmd(1'b0);
    repeat (6) step();
    rst = 1'b0;
    repeat (2) step();
    nChecks++;
    if (outVec() !== 47'd0) begin nFails++; $display("FAIL midreset_outputs: got %h expected 0", outVec()); end
    nChecks++;
    if (dut.state !== IDLE) begin nFails++; $display("FAIL midreset_state: got %0d expected %0d", dut.state, IDLE); end
    rst = 1'b1;
    repeat (2) step();
    nChecks++;
    if (dbg.busy !== 1'b0) begin nFails++; $display("FAIL midreset_busy: got %b expected 0", dbg.busy); end
    nChecks++;
    if (regs[3] !== 16'hBEEF) begin nFails++; $display("FAIL midreset_r3: got %h expected beef", regs[3]); end
    nChecks++;
    if (wrIdxQ.size() != 0) begin nFails++; $display("FAIL midreset_writes: got %0d expected 0", wrIdxQ.size()); end
    preload(3, 16'h1003);
  endtask

  task automatic test_dump();
    int doneAt;
    do_dump(doneAt);
    nChecks++;
    if (doneAt != 32) begin nFails++; $display("FAIL dump_latency: got %0d expected 32", doneAt); end
    nChecks++;
    if (dumpQ.size() != 16) begin nFails++; $display("FAIL dump_count: got %0d expected 16", dumpQ.size()); end
    for (int n = 0; n < 16 && n < dumpQ.size(); n++) begin
      nChecks++;
      if (dumpQ[n] !== 16'(16'h1000 + n)) begin nFails++; $display("FAIL dump_word%0d: got %h expected %h", n, dumpQ[n], 16'(16'h1000 + n)); end
      nChecks++;
      if (lastQ[n] !== (n == 15)) begin nFails++; $display("FAIL dump_last%0d: got %b expected %b", n, lastQ[n], (n == 15)); end
    end
    nChecks++;
    if (doneCount != 1) begin nFails++; $display("FAIL dump_done: got %0d expected 1", doneCount); end
    nChecks++;
    if (dbg.busy !== 1'b0 || dbg.cpu_stall !== 1'b0) begin nFails++; $display("FAIL dump_idle: got busy %b stall %b expected 0 0", dbg.busy, dbg.cpu_stall); end
  endtask

  task automatic test_backpressure();
    int doneAt;
    int held;
    clear_mon();
    dbg.out_ready = 1'b1;
    cmd(1'b0);
    held = 0;
    doneAt = -1;
    for (int c = 1; c <= 200; c++) begin
      if (dbg.out_valid && dumpQ.size() == 7 && held < 5) begin
        nChecks++;
        if (dbg.out_data !== 16'h1007 || dbg.out_last !== 1'b0) begin
          nFails++; $display("FAIL bp_hold%0d: got %h last %b expected 1007 last 0", held, dbg.out_data, dbg.out_last);
        end
        dbg.out_ready = 1'b0;
        held++;
      end else begin
        dbg.out_ready = 1'b1;
      end
      step();
      if (dbg.done) begin doneAt = c; break; end
    end
    dbg.out_ready = 1'b1;
    step();
    nChecks++;
    if (held != 5) begin nFails++; $display("FAIL bp_held: got %0d expected 5", held); end
    nChecks++;
    if (doneAt != 37) begin nFails++; $display("FAIL bp_latency: got %0d expected 37", doneAt); end
    nChecks++;
    if (dumpQ.size() != 16) begin nFails++; $display("FAIL bp_count: got %0d expected 16", dumpQ.size()); end
    for (int n = 0; n < 16 && n < dumpQ.size(); n++) begin
      nChecks++;
      if (dumpQ[n] !== 16'(16'h1000 + n)) begin nFails++; $display("FAIL bp_word%0d: got %h expected %h", n, dumpQ[n], 16'(16'h1000 + n)); end
    end
  endtask

  task automatic test_load();
    int doneAt;
    do_load(16'hA0A0, 1'b0, 1'b0, doneAt);
    nChecks++;
    if (doneAt != 17) begin nFails++; $display("FAIL load_latency: got %0d expected 17", doneAt); end
    nChecks++;
    if (wrIdxQ.size() != 16) begin nFails++; $display("FAIL load_writes: got %0d expected 16", wrIdxQ.size()); end
    for (int n = 0; n < 16 && n < wrIdxQ.size(); n++) begin
      nChecks++;
      if (wrIdxQ[n] !== 4'(n) || wrDataQ[n] !== 16'(16'hA0A0 + n)) begin
        nFails++; $display("FAIL load_write%0d: got idx %0d data %h expected idx %0d data %h", n, wrIdxQ[n], wrDataQ[n], n, 16'(16'hA0A0 + n));
      end
    end
    nChecks++;
    if (doneCount != 1 || dbg.in_ready !== 1'b0) begin nFails++; $display("FAIL load_end: got done %0d in_ready %b expected 1 0", doneCount, dbg.in_ready); end
    do_dump(doneAt);
    nChecks++;
    if (dumpQ.size() != 16) begin nFails++; $display("FAIL load_dump_count: got %0d expected 16", dumpQ.size()); end
    for (int n = 0; n < 16 && n < dumpQ.size(); n++) begin
      nChecks++;
      if (dumpQ[n] !== 16'(16'hA0A0 + n)) begin nFails++; $display("FAIL load_dump%0d: got %h expected %h", n, dumpQ[n], 16'(16'hA0A0 + n)); end
    end
  endtask

  task automatic test_load_gaps();
    int doneAt;
    do_load(16'h5500, 1'b1, 1'b1, doneAt);
    repeat (3) step();
    nChecks++;
    if (doneAt != 32) begin nFails++; $display("FAIL gap_latency: got %0d expected 32", doneAt); end
    nChecks++;
    if (wrIdxQ.size() != 16) begin nFails++; $display("FAIL gap_writes: got %0d expected 16", wrIdxQ.size()); end
    for (int n = 0; n < 16 && n < wrIdxQ.size(); n++) begin
      nChecks++;
      if (wrIdxQ[n] !== 4'(n) || wrDataQ[n] !== 16'(16'h5500 + n)) begin
        nFails++; $display("FAIL gap_write%0d: got idx %0d data %h expected idx %0d data %h", n, wrIdxQ[n], wrDataQ[n], n, 16'(16'h5500 + n));
      end
    end
    nChecks++;
    if (doneCount != 1) begin nFails++; $display("FAIL gap_done: got %0d expected 1", doneCount); end
    nChecks++;
    if (dumpQ.size() != 0 || dbg.busy !== 1'b0 || dut.state !== IDLE) begin
      nFails++; $display("FAIL gap_ignored_cmd: got words %0d busy %b state %0d expected 0 0 %0d", dumpQ.size(), dbg.busy, dut.state, IDLE);
    end
  endtask

  task automatic test_back_to_back();
    int doneAt;
    do_load(16'hC300, 1'b0, 1'b0, doneAt);
    dbg.out_ready = 1'b1;
    cmd(1'b0);
    nChecks++;
    if (dbg.busy !== 1'b1) begin nFails++; $display("FAIL b2b_accept: got busy %b expected 1", dbg.busy); end
    doneAt = -1;
    for (int c = 1; c <= 200; c++) begin
      step();
      if (dbg.done) begin doneAt = c; break; end
    end
    step();
    nChecks++;
    if (doneAt != 32) begin nFails++; $display("FAIL b2b_latency: got %0d expected 32", doneAt); end
    nChecks++;
    if (dumpQ.size() != 16) begin nFails++; $display("FAIL b2b_count: got %0d expected 16", dumpQ.size()); end
    for (int n = 0; n < 16 && n < dumpQ.size(); n++) begin
      nChecks++;
      if (dumpQ[n] !== 16'(16'hC300 + n)) begin nFails++; $display("FAIL b2b_word%0d: got %h expected %h", n, dumpQ[n], 16'(16'hC300 + n)); end
    end
  endtask

  initial begin
    dbg.cmd_valid = 1'b0;
    dbg.cmd_load  = 1'b0;
    dbg.out_ready = 1'b0;
    dbg.in_valid  = 1'b0;
    dbg.in_data   = '0;
    test_reset();
    test_dump();
    test_backpressure();
    test_load();
    test_load_gaps();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
